// File: rtl/rev_alu_pkg.sv
// rev_alu_pkg: shared width, uncompute FSM states and forward DPG tuple type
package rev_alu_pkg;
  localparam int ALU_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} uncomp_state_t;
  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] g;
    logic [ALU_W-1:0] s;
    logic             cout;
  } dpg_tuple_t;
endpackage

// File: rtl/dpg_inv_cell.sv
// dpg_inv_cell: combinational single-bit inverse DPG (p,q,r,s -> a,b,c,d)
module dpg_inv_cell (
  input  logic p,
  input  logic q,
  input  logic r,
  input  logic s,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);
  assign a = p;
  assign b = p ^ q;
  assign c = q ^ r;
  assign d = s ^ (q & c) ^ (a & b);
endmodule

// File: rtl/dpg_serial_uncompute.sv
// dpg_serial_uncompute: bit-serial MSB-first inverse DPG cascade recovering B and Cin; ANCILLA_CHECK_EN adds the ancilla check
module dpg_serial_uncompute
  import rev_alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_g,
  input  logic [W-1:0]     in_s,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic             out_cin,
  output logic             out_err,
  output logic [IDX_W-1:0] out_err_pos,
  output logic             busy
);
  uncomp_state_t    state, state_n;
  logic [W-1:0]     g_q, s_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             cell_a, cell_b, cell_c, cell_d;
  logic             accept;
  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  dpg_inv_cell u_cell (
    .p(out_a[idx]),
    .q(g_q[idx]),
    .r(s_q[idx]),
    .s(carry),
    .a(cell_a),
    .b(cell_b),
    .c(cell_c),
    .d(cell_d)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? RUN : IDLE;
      RUN:     state_n = (idx == '0) ? DONE : RUN;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_a   <= '0;
      out_b   <= '0;
      out_cin <= 1'b0;
      g_q     <= '0;
      s_q     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
    end else if (accept) begin
      out_a <= in_a;
      g_q   <= in_g;
      s_q   <= in_s;
      idx   <= IDX_W'(W - 1);
      carry <= in_cout;
    end else if (state == RUN) begin
      out_b[idx] <= cell_b;
      carry      <= cell_c;
      if (idx == '0) out_cin <= cell_c;
      else           idx     <= idx - 1'b1;
    end
  end
`ifdef ANCILLA_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      out_err     <= 1'b0;
      out_err_pos <= '0;
    end else if (state == RUN && cell_d && !out_err) begin
      out_err     <= 1'b1;
      out_err_pos <= idx;
    end
  end
`else
  assign out_err     = 1'b0;
  assign out_err_pos = '0;
`endif
endmodule

// File: tb/tb_dpg_serial_uncompute.sv
// tb_dpg_serial_uncompute: table-driven directed check of the serial DPG uncompute engine
module tb_dpg_serial_uncompute;
  localparam int W = 16;
`ifdef ANCILLA_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {
    logic [15:0] a, g, s;
    logic        cout;
    logic [15:0] b;
    logic        cin, err;
    logic [3:0]  pos;
  } vec_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, in_cout = 0;
  logic [15:0] in_a = 0, in_g = 0, in_s = 0;
  logic        in_ready, out_valid, out_cin, out_err, busy;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_err_pos;
  int checks = 0, fails = 0;
  vec_t v[6];
  dpg_serial_uncompute #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_g(in_g), .in_s(in_s), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_cin(out_cin), .out_err(out_err), .out_err_pos(out_err_pos), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic start(input vec_t t);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_start", 32'(in_ready), 1);
    in_a = t.a; in_g = t.g; in_s = t.s; in_cout = t.cout; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic run(input vec_t t, input string tag);
    int n = 0;
    start(t);
    chk({tag, "_busy"}, 32'(busy), 1);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, 16);
    chk({tag, "_a"}, 32'(out_a), 32'(t.a));
    chk({tag, "_b"}, 32'(out_b), 32'(t.b));
    chk({tag, "_cin"}, 32'(out_cin), 32'(t.cin));
    chk({tag, "_err"}, 32'(out_err), CHK ? 32'(t.err) : 0);
    chk({tag, "_pos"}, 32'(out_err_pos), CHK ? 32'(t.pos) : 0);
  endtask
  task automatic release_out(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_valid_cleared"}, 32'(out_valid), 0);
    chk({tag, "_ready_back"}, 32'(in_ready), 1);
  endtask
  initial begin
    v[0] = '{16'h1234, 16'h444C, 16'h68AC, 1'b0, 16'h5678, 1'b0, 1'b0, 4'd0};
    v[1] = '{16'hFFFF, 16'hFFFE, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4'd0};
    v[2] = '{16'h1234, 16'h444C, 16'h68AC, 1'b1, 16'h5678, 1'b0, 1'b1, 4'd15};
    v[3] = '{16'h0001, 16'h0003, 16'h0004, 1'b0, 16'h0002, 1'b1, 1'b0, 4'd0};
    v[4] = '{16'h8000, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 4'd0};
    v[5] = '{16'h0000, 16'h0000, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd7};
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_b", 32'(out_b), 0);
    chk("rst_a", 32'(out_a), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);
    run(v[0], "v0");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_a = v[1].a; in_g = v[1].g; in_s = v[1].s; in_cout = v[1].cout; in_valid = 1;
      end
      @(negedge clk);
      in_valid = 0;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_b", 32'(out_b), 32'(v[0].b));
      chk("hold_a", 32'(out_a), 32'(v[0].a));
    end
    release_out("v0");
    @(negedge clk);
    chk("no_second_take", 32'(busy), 0);
    for (int i = 1; i < 6; i++) begin
      run(v[i], $sformatf("v%0d", i));
      release_out($sformatf("v%0d", i));
    end
    start(v[0]);
    repeat (8) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_a", 32'(out_a), 0);
    chk("abort_b", 32'(out_b), 0);
    chk("abort_cin", 32'(out_cin), 0);
    chk("abort_err", 32'(out_err), 0);
    chk("abort_ready", 32'(in_ready), 1);
    run(v[0], "rerun");
    release_out("rerun");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
